// File: rtl/debounced_input_pio.sv
// Debounced input port for push-buttons and slide switches on the Avalon-MM bus.
// Each channel is synchronised, optionally inverted and debounced. Edges of the
// debounced value are captured into a write-1-to-clear register that drives a
// maskable level interrupt.
module debounced_input_pio #(
  parameter int               WIDTH           = 10,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] pins_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_next;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] wr_clear;
  logic             unused_wdata;

  assign s     = sync2 ^ INVERT_MASK;
  assign wdata = avs_writedata[WIDTH-1:0];

  // Bits of the write bus above WIDTH have no register behind them.
  assign unused_wdata = ^avs_writedata;

  // Two-flop synchroniser moves the asynchronous pins into the clock domain.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins_in;
      sync2 <= sync1;
    end
  end

  // Per-channel stability counter: a change is accepted only after it has held
  // for DEBOUNCE_CYCLES consecutive cycles; any return to deb restarts the count.
  always_comb begin
    deb_next = deb;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced state and counters.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb <= deb_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Edges are taken from the debounced value on the cycle it changes.
  assign rise = deb_next & ~deb;
  assign fall = ~deb_next & deb;
  assign hit  = (EDGE_MODE == 0) ? rise : ((EDGE_MODE == 1) ? fall : (rise | fall));

  assign wr_clear = (avs_write && (avs_address == ADDR_EDGECAP)) ? wdata : '0;

  // Interrupt mask and edge capture; a new hit beats a same-cycle clear.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      irqmask <= '0;
      edgecap <= '0;
    end else begin
      if (avs_write && (avs_address == ADDR_IRQMASK)) begin
        irqmask <= wdata;
      end
      edgecap <= (edgecap & ~wr_clear) | hit;
    end
  end

  // Registered read port; holds the last read value between reads.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      case (avs_address)
        ADDR_DATA:    avs_readdata <= 32'(deb);
        ADDR_RAW:     avs_readdata <= 32'(s);
        ADDR_IRQMASK: avs_readdata <= 32'(irqmask);
        default:      avs_readdata <= 32'(edgecap);
      endcase
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_debounced_input_pio.sv
// Testbench for debounced_input_pio. Three instances with different edge modes
// and inversion masks share one stimulus stream; each has its own reference
// model and scoreboard monitor.
module tb_debounced_input_pio;

  localparam int DB = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  pins;
  logic        rd;
  logic        wr;
  logic [1:0]  addr;
  logic [31:0] wdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input int cfg_id, input string name,
                             input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL cfg%0d %s at %0t: got 0x%08h, expected 0x%08h",
               cfg_id, name, $time, actual, expected);
    end
  endtask

  // Drives one cycle of inputs starting at a falling edge.
  task automatic applyStimulus(input logic [3:0] p, input logic r, input logic w,
                               input logic [1:0] a, input logic [31:0] d);
    pins  = p;
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int         MODE = g;
    localparam logic [3:0] INV  = (g == 0) ? 4'h0 : ((g == 1) ? 4'hF : 4'h5);

    logic [31:0] rdata;
    logic        irq_o;

    debounced_input_pio #(
      .WIDTH(4), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(MODE), .INVERT_MASK(INV)
    ) dut (
      .clk_clk(clk), .reset_reset(rst), .pins_in(pins),
      .avs_address(addr), .avs_read(rd), .avs_write(wr), .avs_writedata(wdata),
      .avs_readdata(rdata), .irq(irq_o)
    );

    logic [3:0]  m_deb;
    logic [3:0]  m_raw;
    logic [3:0]  m_mask;
    logic [3:0]  m_cap;
    logic [3:0]  pin_hist[$];
    logic [3:0]  s_win[$];
    logic [31:0] exp_q[$];
    logic [3:0]  s_now;
    logic [3:0]  deb_new;
    logic [3:0]  edge_hit;
    logic [3:0]  clr;
    logic        agree;
    bit          rd_due;

    // Reference model: a channel flips when the last DB conditioned samples all
    // disagree with its debounced value; reads return pre-edge register contents.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_deb  = '0;
        m_mask = '0;
        m_cap  = '0;
        m_raw  = INV;
        pin_hist.delete();
        pin_hist.push_back(4'h0);
        pin_hist.push_back(4'h0);
        s_win.delete();
        exp_q.delete();
        rd_due = 0;
      end else begin
        rd_due = rd;
        if (rd) begin
          case (addr)
            2'd0:    exp_q.push_back(32'(m_deb));
            2'd1:    exp_q.push_back(32'(m_raw));
            2'd2:    exp_q.push_back(32'(m_mask));
            default: exp_q.push_back(32'(m_cap));
          endcase
        end
        s_now = pin_hist[1] ^ INV;
        s_win.push_front(s_now);
        if (s_win.size() > DB) void'(s_win.pop_back());
        deb_new = m_deb;
        if (s_win.size() == DB) begin
          for (int c = 0; c < 4; c++) begin
            agree = 1'b0;
            foreach (s_win[k]) if (s_win[k][c] == m_deb[c]) agree = 1'b1;
            if (!agree) deb_new[c] = ~m_deb[c];
          end
        end
        pin_hist.push_front(pins);
        void'(pin_hist.pop_back());
        m_raw = pin_hist[1] ^ INV;
        if (MODE == 0)      edge_hit = deb_new & ~m_deb;
        else if (MODE == 1) edge_hit = ~deb_new & m_deb;
        else                edge_hit = deb_new ^ m_deb;
        clr = (wr && addr == 2'd3) ? wdata[3:0] : 4'h0;
        m_cap = (m_cap & ~clr) | edge_hit;
        if (wr && addr == 2'd2) m_mask = wdata[3:0];
        m_deb = deb_new;
      end
    end

    // Monitor: checks irq every cycle and pops the scoreboard when read data is due.
    always begin
      @(posedge clk);
      #3;
      if (!rst) begin
        checkOutput(g, "irq", 32'(irq_o), 32'(|(m_cap & m_mask)));
        if (rd_due) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL cfg%0d readdata at %0t: got 0x%08h, expected entry missing",
                     g, $time, rdata);
          end else begin
            checkOutput(g, "readdata", rdata, exp_q.pop_front());
          end
        end
      end
    end
  end

  logic [3:0] rnd_pins;
  logic [3:0] flip;
  int         sel;

  initial begin
    clk = 0; rst = 1; pins = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    rst = 0;

    $display("[TB] reset values");
    for (int a = 0; a < 4; a++) applyStimulus(4'h0, 1, 0, 2'(a), 0);

    $display("[TB] single rising input");
    for (int i = 0; i < 10; i++) applyStimulus(4'h1, 1, 0, 2'd0, 0);
    applyStimulus(4'h1, 1, 0, 2'd3, 0);
    applyStimulus(4'h1, 0, 1, 2'd2, 32'h1);
    applyStimulus(4'h1, 1, 0, 2'd2, 0);
    applyStimulus(4'h1, 0, 0, 2'd0, 0);

    $display("[TB] short glitch");
    for (int i = 0; i < 3; i++) applyStimulus(4'h5, 1, 0, 2'd1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(4'h1, 1, 0, 2'd1, 0);
    applyStimulus(4'h1, 1, 0, 2'd0, 0);
    applyStimulus(4'h1, 1, 0, 2'd3, 0);

    $display("[TB] clear colliding with capture");
    applyStimulus(4'h1, 0, 1, 2'd2, 32'hF);
    applyStimulus(4'h1, 0, 1, 2'd3, 32'hF);
    for (int i = 0; i < 9; i++) applyStimulus(4'h9, 0, 1, 2'd3, 32'h8);
    applyStimulus(4'h9, 1, 0, 2'd3, 0);
    applyStimulus(4'h9, 0, 1, 2'd3, 32'hF);
    applyStimulus(4'h9, 1, 0, 2'd3, 0);
    applyStimulus(4'h9, 0, 0, 2'd0, 0);

    $display("[TB] inverted inputs high from reset");
    rst = 1;
    applyStimulus(4'hF, 0, 0, 2'd0, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) applyStimulus(4'hF, 1, 0, 2'd0, 0);
    applyStimulus(4'hF, 1, 0, 2'd3, 0);
    applyStimulus(4'hF, 0, 1, 2'd3, 32'hF);
    applyStimulus(4'hF, 0, 1, 2'd2, 32'hF);
    for (int i = 0; i < 8; i++) applyStimulus(4'hD, 1, 0, 2'd0, 0);
    applyStimulus(4'hD, 1, 0, 2'd3, 0);
    for (int i = 0; i < 8; i++) applyStimulus(4'hF, 1, 0, 2'd3, 0);

    $display("[TB] reset during debounce");
    applyStimulus(4'h0, 0, 0, 2'd0, 0);
    rst = 1;
    applyStimulus(4'h0, 0, 0, 2'd0, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) applyStimulus(4'h2, 1, 0, 2'd0, 0);
    rst = 1;
    applyStimulus(4'h2, 0, 0, 2'd0, 0);
    rst = 0;
    for (int a = 0; a < 4; a++) applyStimulus(4'h2, 1, 0, 2'(a), 0);
    for (int i = 0; i < 6; i++) applyStimulus(4'h2, 1, 0, 2'd0, 0);
    applyStimulus(4'h2, 1, 0, 2'd3, 0);

    $display("[TB] random traffic");
    rnd_pins = 4'h2;
    for (int i = 0; i < 1500; i++) begin
      flip = '0;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) flip[b] = 1'b1;
      rnd_pins = rnd_pins ^ flip;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      applyStimulus(rnd_pins, 1, 0, 2'($urandom_range(0, 3)), 0);
      else if (sel < 7) applyStimulus(rnd_pins, 0, 1, 2'($urandom_range(0, 3)), $urandom);
      else              applyStimulus(rnd_pins, 0, 0, 2'd0, 0);
    end

    applyStimulus(rnd_pins, 0, 0, 2'd0, 0);
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
